// File: rtl/gs_cfg_pkg.sv
// Shared definitions for the NeoGS ACEX1K passive-serial loader: FSM encoding, error codes,
// default ACEX1K timing constants and a counter-width helper.
package gs_cfg_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StNcfg,
        StWaitSt,
        StLoad,
        StCheck,
        StFlush,
        StWaitInit,
        StDone,
        StErr
    } gs_state_e;

    localparam logic [1:0] ERR_NONE         = 2'b00;
    localparam logic [1:0] ERR_NSTATUS      = 2'b01;
    localparam logic [1:0] ERR_NO_CONF_DONE = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT      = 2'b11;

    localparam int unsigned AcexDclkDiv  = 2;
    localparam int unsigned AcexNcfgLow  = 48;
    localparam int unsigned AcexInitClks = 10;
    localparam int unsigned AcexTimeout  = 1 << 20;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gs_ps_shifter.sv
// LSB-first bit shifter and DCLK generator: DclkDiv cycles low (data changes here), then
// DclkDiv cycles high per bit. Reports empty and the final cycle of the last bit.
module gs_ps_shifter
    import gs_cfg_pkg::*;
#(
    parameter int unsigned DclkDiv = AcexDclkDiv,
    parameter int unsigned BitW    = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            load_i,
    input  logic [7:0]      data_i,
    input  logic [BitW-1:0] bits_i,
    output logic            dclk_o,
    output logic            data0_o,
    output logic            empty_o,
    output logic            last_bit_o
);

    localparam int unsigned PhW = cnt_width(DclkDiv);

    logic [7:0]      sreg_q, sreg_d;
    logic [BitW-1:0] bits_q, bits_d;
    logic [PhW-1:0]  phase_q, phase_d;
    logic            dclk_q, dclk_d;
    logic            phase_end;

    assign empty_o    = (bits_q == '0);
    assign phase_end  = (phase_q == PhW'(DclkDiv - 1));
    assign last_bit_o = !empty_o && dclk_q && phase_end && (bits_q == BitW'(1));
    assign dclk_o     = dclk_q;
    assign data0_o    = !empty_o && sreg_q[0];

    always_comb begin
        sreg_d  = sreg_q;
        bits_d  = bits_q;
        phase_d = phase_q;
        dclk_d  = dclk_q;
        if (clr_i) begin
            sreg_d  = '0;
            bits_d  = '0;
            phase_d = '0;
            dclk_d  = 1'b0;
        end else begin
            if (!empty_o) begin
                if (phase_end) begin
                    phase_d = '0;
                    if (!dclk_q) begin
                        dclk_d = 1'b1;
                    end else begin
                        dclk_d = 1'b0;
                        sreg_d = sreg_q >> 1;
                        bits_d = bits_q - BitW'(1);
                    end
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            // A load lands either on an idle shifter or on the closing cycle of the last bit.
            if (load_i) begin
                sreg_d  = data_i;
                bits_d  = bits_i;
                phase_d = '0;
                dclk_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sreg_q  <= '0;
            bits_q  <= '0;
            phase_q <= '0;
            dclk_q  <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            bits_q  <= bits_d;
            phase_q <= phase_d;
            dclk_q  <= dclk_d;
        end
    end

endmodule

// File: rtl/gs_fpga_ps_loader.sv
// ACEX1K passive-serial configuration engine: FSM, status synchronisers and optional
// watchdog (enabled by defining GS_LOADER_TIMEOUT_EN).
module gs_fpga_ps_loader
    import gs_cfg_pkg::*;
#(
    parameter int unsigned DCLK_DIV  = AcexDclkDiv,
    parameter int unsigned NCFG_LOW  = AcexNcfgLow,
    parameter int unsigned INIT_CLKS = AcexInitClks
`ifdef GS_LOADER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT   = AcexTimeout
`endif
) (
    input  logic       clkin,
    input  logic       coldres_n,
    input  logic       start,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic       config_n,
    input  logic       status_n,
    input  logic       conf_done,
    input  logic       init_done,
    output logic       dclk,
    output logic       data0,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    localparam int unsigned NcW  = cnt_width(NCFG_LOW);
    localparam int unsigned BitW = cnt_width(((INIT_CLKS > 8) ? INIT_CLKS : 8) + 1);

    gs_state_e       state_q, state_d;
    logic [NcW-1:0]  ncfg_q, ncfg_d;
    logic [1:0]      err_q, err_d;
    logic            last_q, last_d;
    logic [2:0]      sync1_q, sync2_q;
    logic            status_s, conf_s, init_s;
    logic            sh_load, sh_clr, sh_empty, sh_last_bit;
    logic [7:0]      sh_data;
    logic [BitW-1:0] sh_bits;
    logic            wd_hit;

    always_ff @(posedge clkin) begin
        if (!coldres_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {init_done, conf_done, status_n};
            sync2_q <= sync1_q;
        end
    end

    assign status_s = sync2_q[0];
    assign conf_s   = sync2_q[1];
    assign init_s   = sync2_q[2];

`ifdef GS_LOADER_TIMEOUT_EN
    localparam int unsigned WdW = cnt_width(TIMEOUT);

    logic [WdW-1:0] wd_q, wd_d;
    logic           wd_run;

    // Load only counts while starved; an active shifter proves the host is alive.
    assign wd_run = (state_q == StWaitSt) || (state_q == StWaitInit) ||
                    ((state_q == StLoad) && sh_empty);
    assign wd_hit = wd_run && (wd_q == WdW'(TIMEOUT - 1));
    assign wd_d   = (wd_run && !wd_hit) ? wd_q + WdW'(1) : '0;

    always_ff @(posedge clkin) begin
        if (!coldres_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ncfg_d     = ncfg_q;
        err_d      = err_q;
        last_d     = last_q;
        sh_load    = 1'b0;
        sh_clr     = 1'b0;
        sh_data    = byte_data;
        sh_bits    = BitW'(8);
        byte_ready = 1'b0;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StNcfg;
                    ncfg_d  = '0;
                    err_d   = ERR_NONE;
                end
            end
            StNcfg: begin
                if (ncfg_q == NcW'(NCFG_LOW - 1)) begin
                    state_d = StWaitSt;
                end else begin
                    ncfg_d = ncfg_q + NcW'(1);
                end
            end
            StWaitSt: begin
                if (status_s) begin
                    state_d = StLoad;
                    last_d  = 1'b0;
                end
            end
            StLoad: begin
                if (!status_s) begin
                    state_d = StErr;
                    err_d   = ERR_NSTATUS;
                    sh_clr  = 1'b1;
                end else begin
                    byte_ready = sh_empty || (sh_last_bit && !last_q);
                    if (byte_valid && byte_ready) begin
                        sh_load = 1'b1;
                        last_d  = byte_last;
                    end else if (sh_last_bit && last_q) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (conf_s) begin
                    state_d = StFlush;
                    sh_load = 1'b1;
                    sh_data = 8'h00;
                    sh_bits = BitW'(INIT_CLKS);
                end else begin
                    state_d = StErr;
                    err_d   = ERR_NO_CONF_DONE;
                end
            end
            StFlush: begin
                if (!status_s) begin
                    state_d = StErr;
                    err_d   = ERR_NSTATUS;
                    sh_clr  = 1'b1;
                end else if (sh_last_bit) begin
                    state_d = StWaitInit;
                end
            end
            StWaitInit: begin
                if (init_s) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
        if (wd_hit && (state_d != StErr)) begin
            state_d    = StErr;
            err_d      = ERR_TIMEOUT;
            sh_clr     = 1'b1;
            sh_load    = 1'b0;
            byte_ready = 1'b0;
        end
    end

    always_ff @(posedge clkin) begin
        if (!coldres_n) begin
            state_q <= StIdle;
            ncfg_q  <= '0;
            err_q   <= ERR_NONE;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ncfg_q  <= ncfg_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    gs_ps_shifter #(
        .DclkDiv(DCLK_DIV),
        .BitW   (BitW)
    ) u_shifter (
        .clk_i     (clkin),
        .rst_ni    (coldres_n),
        .clr_i     (sh_clr),
        .load_i    (sh_load),
        .data_i    (sh_data),
        .bits_i    (sh_bits),
        .dclk_o    (dclk),
        .data0_o   (data0),
        .empty_o   (sh_empty),
        .last_bit_o(sh_last_bit)
    );

    assign config_n = (state_q != StNcfg);
    assign busy     = !((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
    assign done     = (state_q == StDone);
    assign error    = (state_q == StErr);
    assign err_code = err_q;

endmodule

// File: tb/tb_gs_fpga_ps_loader.sv
// Directed bench for gs_fpga_ps_loader with a hand-driven ACEX1K pin model.
module tb_gs_fpga_ps_loader;

    logic       clkin = 1'b0;
    logic       coldres_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_last = 1'b0;
    logic       status_n = 1'b1;
    logic       conf_done = 1'b0;
    logic       init_done = 1'b0;
    logic       byte_ready, config_n, dclk, data0, busy, done, error;
    logic [1:0] err_code;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    logic dclk_prev = 1'b0;
    int   rise_cyc[$];
    logic rise_dat[$];
    int   accept_cyc[$];

    always #5 clkin = ~clkin;

    always @(posedge clkin) cyc <= cyc + 1;

    always @(negedge clkin) begin
        if (dclk && !dclk_prev) begin
            rise_cyc.push_back(cyc);
            rise_dat.push_back(data0);
        end
        dclk_prev = dclk;
    end

    gs_fpga_ps_loader #(
        .DCLK_DIV (2),
        .NCFG_LOW (48),
        .INIT_CLKS(10)
`ifdef GS_LOADER_TIMEOUT_EN
        ,
        .TIMEOUT  (1000)
`endif
    ) u_dut (
        .clkin     (clkin),
        .coldres_n (coldres_n),
        .start     (start),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_last (byte_last),
        .byte_ready(byte_ready),
        .config_n  (config_n),
        .status_n  (status_n),
        .conf_done (conf_done),
        .init_done (init_done),
        .dclk      (dclk),
        .data0     (data0),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    task automatic do_reset();
        coldres_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
        status_n = 1'b1; conf_done = 1'b0; init_done = 1'b0;
        repeat (3) @(posedge clkin);
        #1 coldres_n = 1'b1;
        rise_cyc.delete(); rise_dat.delete(); accept_cyc.delete();
    endtask

    task automatic pulse_start();
        @(posedge clkin); #1 start = 1'b1;
        @(posedge clkin); #1 start = 1'b0;
    endtask

    // Start, hold nSTATUS low while nCONFIG is low, release it 10 cycles after nCONFIG rises.
    task automatic bring_up(output int low_cycles);
        int n;
        low_cycles = 0;
        n = 0;
        pulse_start();
        status_n = 1'b0;
        while (n < 200) begin
            @(negedge clkin);
            if (config_n == 1'b0) low_cycles++;
            else if (low_cycles > 0) break;
            n++;
        end
        repeat (10) @(posedge clkin);
        #1 status_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int  n;
        bit  ok;
        n = 0; ok = 1'b0;
        byte_data = d; byte_last = last; byte_valid = 1'b1;
        while (n < 300) begin
            @(negedge clkin);
            if (byte_ready) begin
                ok = 1'b1;
                accept_cyc.push_back(cyc);
                break;
            end
            n++;
        end
        @(posedge clkin); #1 byte_valid = 1'b0; byte_last = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL byte_accept 0x%02h: not accepted within 300 cycles", d);
        end
    endtask

    task automatic test_reset();
        coldres_n = 1'b0; start = 1'b1;
        repeat (2) @(posedge clkin);
        @(negedge clkin);
        tests_run++; if (config_n !== 1'b1) begin tests_failed++; $display("FAIL reset_config_n got=%b want=1", config_n); end
        tests_run++; if (dclk !== 1'b0) begin tests_failed++; $display("FAIL reset_dclk got=%b want=0", dclk); end
        tests_run++; if (data0 !== 1'b0) begin tests_failed++; $display("FAIL reset_data0 got=%b want=0", data0); end
        tests_run++; if (byte_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_byte_ready got=%b want=0", byte_ready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b want=0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b want=0", done); end
        tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL reset_error got=%b want=0", error); end
        tests_run++; if (err_code !== 2'b00) begin tests_failed++; $display("FAIL reset_err_code got=%b want=00", err_code); end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int low, n, nrise;
        do_reset();
        bring_up(low);
        send_byte(8'hFF, 1'b0);
        n = 0;
        while (rise_cyc.size() < 3 && n < 100) begin @(negedge clkin); n++; end
        tests_run++; if (rise_cyc.size() < 3) begin tests_failed++; $display("FAIL midload_bits got=%0d want=3", rise_cyc.size()); end
        @(posedge clkin); #1 coldres_n = 1'b0;
        @(posedge clkin);
        @(negedge clkin);
        nrise = rise_cyc.size();
        tests_run++; if (config_n !== 1'b1) begin tests_failed++; $display("FAIL midload_config_n got=%b want=1", config_n); end
        tests_run++; if (dclk !== 1'b0) begin tests_failed++; $display("FAIL midload_dclk got=%b want=0", dclk); end
        tests_run++; if (byte_ready !== 1'b0) begin tests_failed++; $display("FAIL midload_byte_ready got=%b want=0", byte_ready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midload_busy got=%b want=0", busy); end
        @(posedge clkin); #1 coldres_n = 1'b1;
        repeat (12) @(negedge clkin);
        tests_run++; if (rise_cyc.size() != nrise) begin tests_failed++; $display("FAIL midload_extra_dclk got=%0d want=%0d", rise_cyc.size(), nrise); end
    endtask

    task automatic test_load();
        int low, n, bad;
        logic [25:0] got;
        logic [25:0] exp;
        exp = {10'b0, 8'h3C, 8'hA5};
        do_reset();
        bring_up(low);
        tests_run++; if (low != 48) begin tests_failed++; $display("FAIL ncfg_low_cycles got=%0d want=48", low); end
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b1);
        conf_done = 1'b1;
        pulse_start();  // busy: must be ignored
        n = 0;
        while (!done && n < 500) begin
            @(negedge clkin);
            if (rise_cyc.size() >= 26 && !init_done) begin
                tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL done_before_init got=%b want=0", done); end
                init_done = 1'b1;
            end
            n++;
        end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL load_done got=%b want=1", done); end
        tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL load_error got=%b want=0", error); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL load_busy got=%b want=0", busy); end
        tests_run++; if (err_code !== 2'b00) begin tests_failed++; $display("FAIL load_err_code got=%b want=00", err_code); end
        tests_run++; if (rise_dat.size() != 26) begin tests_failed++; $display("FAIL dclk_rises got=%0d want=26", rise_dat.size()); end
        got = '0;
        for (int i = 0; i < rise_dat.size() && i < 26; i++) got[i] = rise_dat[i];
        tests_run++; if (got !== exp) begin tests_failed++; $display("FAIL data0_stream got=%b want=%b", got, exp); end
        if (rise_cyc.size() >= 26 && accept_cyc.size() == 2) begin
            tests_run++; if (rise_cyc[0] - accept_cyc[0] != 3) begin tests_failed++; $display("FAIL first_rise_latency got=%0d want=3", rise_cyc[0] - accept_cyc[0]); end
            tests_run++; if (rise_cyc[8] - accept_cyc[1] != 3) begin tests_failed++; $display("FAIL byte2_rise_latency got=%0d want=3", rise_cyc[8] - accept_cyc[1]); end
            bad = 0;
            for (int i = 1; i < 16; i++) if (rise_cyc[i] - rise_cyc[i-1] != 4) bad++;
            tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL load_dclk_period bad_intervals=%0d want=0", bad); end
            bad = 0;
            for (int i = 17; i < 26; i++) if (rise_cyc[i] - rise_cyc[i-1] != 4) bad++;
            tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL flush_dclk_period bad_intervals=%0d want=0", bad); end
        end else begin
            tests_run++; tests_failed++;
            $display("FAIL timing_capture rises=%0d accepts=%0d want=26,2", rise_cyc.size(), accept_cyc.size());
        end
        repeat (5) @(negedge clkin);
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL done_held got=%b want=1", done); end
        pulse_start();
        @(negedge clkin);
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL restart_done got=%b want=0", done); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL restart_busy got=%b want=1", busy); end
        tests_run++; if (config_n !== 1'b0) begin tests_failed++; $display("FAIL restart_config_n got=%b want=0", config_n); end
    endtask

    task automatic test_nstatus_err();
        int low, n, nrise;
        do_reset();
        bring_up(low);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (3) @(posedge clkin);
        #1 status_n = 1'b0;
        n = 0;
        while (!error && n < 50) begin @(negedge clkin); n++; end
        nrise = rise_cyc.size();
        tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL nst_error got=%b want=1", error); end
        tests_run++; if (err_code !== 2'b01) begin tests_failed++; $display("FAIL nst_err_code got=%b want=01", err_code); end
        tests_run++; if (dclk !== 1'b0) begin tests_failed++; $display("FAIL nst_dclk got=%b want=0", dclk); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL nst_done got=%b want=0", done); end
        tests_run++; if (byte_ready !== 1'b0) begin tests_failed++; $display("FAIL nst_byte_ready got=%b want=0", byte_ready); end
        repeat (20) @(negedge clkin);
        tests_run++; if (rise_cyc.size() != nrise) begin tests_failed++; $display("FAIL nst_extra_dclk got=%0d want=%0d", rise_cyc.size(), nrise); end
        tests_run++; if (nrise >= 16) begin tests_failed++; $display("FAIL nst_stop_mid_byte rises=%0d want<16", nrise); end
    endtask

    task automatic test_no_conf_done();
        int low, n;
        do_reset();
        bring_up(low);
        send_byte(8'h5A, 1'b1);
        n = 0;
        while (!error && n < 100) begin @(negedge clkin); n++; end
        tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL ncd_error got=%b want=1", error); end
        tests_run++; if (err_code !== 2'b10) begin tests_failed++; $display("FAIL ncd_err_code got=%b want=10", err_code); end
        repeat (20) @(negedge clkin);
        tests_run++; if (rise_cyc.size() != 8) begin tests_failed++; $display("FAIL ncd_rises got=%0d want=8", rise_cyc.size()); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ncd_busy got=%b want=0", busy); end
    endtask

    task automatic test_watchdog();
        int n, t0, t1;
        do_reset();
        pulse_start();
        status_n = 1'b0;
        t0 = cyc - 1;
`ifdef GS_LOADER_TIMEOUT_EN
        n = 0;
        while (!error && n < 3000) begin @(negedge clkin); n++; end
        t1 = cyc;
        tests_run++; if (error !== 1'b1) begin tests_failed++; $display("FAIL wd_error got=%b want=1", error); end
        tests_run++; if (err_code !== 2'b11) begin tests_failed++; $display("FAIL wd_err_code got=%b want=11", err_code); end
        tests_run++; if (config_n !== 1'b1) begin tests_failed++; $display("FAIL wd_config_n got=%b want=1", config_n); end
        tests_run++; if (t1 - t0 < 1040 || t1 - t0 > 1060) begin tests_failed++; $display("FAIL wd_latency got=%0d want=1040..1060", t1 - t0); end
`else
        n = 0;
        repeat (1500) @(negedge clkin);
        t1 = cyc;
        tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL nowd_error got=%b want=0 after %0d cycles", error, t1 - t0); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL nowd_busy got=%b want=1", busy); end
`endif
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_reset_mid_load();
        test_load();
        test_nstatus_err();
        test_no_conf_done();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
